// File: rtl/full_adder.sv
// Registered ripple-carry adder built from one-bit full-adder cells, with carry-out and signed overflow.
// Optional input register stage via FULL_ADDER_INREG_EN (latency 2 instead of 1).

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
`ifdef FULL_ADDER_INREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  // arm_q blocks capture on the first edge after reset release
  logic             arm_q;
  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) arm_q <= 1'b0;
    else        arm_q <= 1'b1;

  assign vld_pipe[0] = in_valid & arm_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];

`ifdef FULL_ADDER_INREG_EN
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  assign c[0] = op_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a_i (op_a[i]),
      .b_i (op_b[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (vld_pipe[STAGES-1]) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 instances checked against an arithmetic reference model.
module tb_full_adder;
`ifdef FULL_ADDER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic a1, b1, c1;
  logic [7:0] a8, b8;
  logic c8;
  logic ov1, s1, co1, of1;
  logic ov8, co8, of8;
  logic [7:0] s8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8), .ovf(of8)
  );

  typedef struct {
    bit       v;
    bit       a1, b1, c1;
    bit [7:0] a8, b8;
    bit       c8;
  } op_t;

  op_t pend[$];
  bit       first_edge;
  bit       e_vld;
  bit       e1_s, e1_co, e1_of;
  bit [7:0] e8_s;
  bit       e8_co, e8_of;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w1.out_valid", 64'(ov1), 64'(e_vld));
    chk("w1.sum",       64'(s1),  64'(e1_s));
    chk("w1.cout",      64'(co1), 64'(e1_co));
    chk("w1.ovf",       64'(of1), 64'(e1_of));
    chk("w8.out_valid", 64'(ov8), 64'(e_vld));
    chk("w8.sum",       64'(s8),  64'(e8_s));
    chk("w8.cout",      64'(co8), 64'(e8_co));
    chk("w8.ovf",       64'(of8), 64'(e8_of));
  endtask

  // Reference: unsigned total gives sum/cout, signed total range gives overflow
  function automatic void calc8(input int a, input int b, input int c,
                                output bit [7:0] s, output bit co, output bit ov);
    int t, sa, sb, ss;
    t  = a + b + c;
    s  = 8'(t % 256);
    co = (t > 255);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    ss = sa + sb + c;
    ov = (ss > 127) || (ss < -128);
  endfunction

  function automatic void calc1(input int a, input int b, input int c,
                                output bit s, output bit co, output bit ov);
    int t, ss;
    t  = a + b + c;
    s  = bit'(t % 2);
    co = (t > 1);
    ss = -a - b + c;
    ov = (ss > 0) || (ss < -1);
  endfunction

  task automatic reset_model();
    op_t z;
    z = '{default: 0};
    pend.delete();
    for (int i = 0; i < LAT - 1; i++) pend.push_back(z);
    first_edge = 1'b1;
    e_vld = 0; e1_s = 0; e1_co = 0; e1_of = 0; e8_s = 0; e8_co = 0; e8_of = 0;
  endtask

  task automatic tick();
    op_t cur, eff;
    cur.v  = in_valid;
    cur.a1 = a1; cur.b1 = b1; cur.c1 = c1;
    cur.a8 = a8; cur.b8 = b8; cur.c8 = c8;
    @(posedge clk);
    #1;
    if (first_edge) cur.v = 1'b0;
    first_edge = 1'b0;
    pend.push_back(cur);
    eff = pend.pop_front();
    e_vld = eff.v;
    if (eff.v) begin
      calc1(int'(eff.a1), int'(eff.b1), int'(eff.c1), e1_s, e1_co, e1_of);
      calc8(int'(eff.a8), int'(eff.b8), int'(eff.c8), e8_s, e8_co, e8_of);
    end
    check_all();
  endtask

  task automatic drive(input bit v, input bit [2:0] abc1, input bit [7:0] xa, input bit [7:0] xb, input bit xc);
    in_valid = v;
    {a1, b1, c1} = abc1;
    a8 = xa; b8 = xb; c8 = xc;
  endtask

  task automatic drive_rand();
    drive(bit'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  bit [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h80};
  bit [7:0] tb [3] = '{8'h00, 8'h01, 8'h80};
  bit       tc [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    drive(0, 3'b000, 8'h00, 8'h00, 0);
    reset_model();
    #2;
    check_all();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    drive(1, 3'b111, 8'hAA, 8'h55, 1);  // ignored on first edge after release
    tick();

    // WIDTH=1 exhaustive combos alongside WIDTH=8 corner cases, back to back
    for (int i = 0; i < 8; i++) begin
      if (i < 3) drive(1, 3'(i), ta[i], tb[i], tc[i]);
      else       drive(1, 3'(i), 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    drive(0, 3'b000, 8'h00, 8'h00, 0);
    repeat (LAT + 1) tick();

    // hold: one valid add then operands change with in_valid low
    drive(1, 3'b010, 8'h12, 8'h34, 0);
    tick();
    drive(0, 3'b111, 8'hFF, 8'hFF, 1);
    repeat (LAT + 2) tick();
    chk("hold.sum", 64'(s8), 64'h46);
    chk("hold.cout", 64'(co8), 64'h0);
    chk("hold.out_valid", 64'(ov8), 64'h0);

    repeat (40) begin
      drive_rand();
      tick();
    end

    // reset asserted between edges with a result in flight
    drive(1, 3'b011, 8'hF0, 8'h0F, 1);
    tick();
    drive(1, 3'b101, 8'h80, 8'hFF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    tick();
    drive(0, 3'b000, 8'h00, 8'h00, 0);
    repeat (LAT + 1) tick();
    drive(1, 3'b110, 8'h7F, 8'h7F, 1);
    tick();
    drive(0, 3'b000, 8'h00, 8'h00, 0);
    repeat (LAT + 1) tick();

    repeat (20) begin
      drive_rand();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
